// File: rtl/ls161_div_sequencer.sv
// ---------------------------------------------------------------------------
// ls161_div_sequencer
//
// Drives a 74LS161-style 4-bit synchronous counter so that it divides the
// shared clock by a programmable ratio N. The counter is preloaded with
// (2^WIDTH - N). When its ripple-carry output (RCO) shows all ones, the
// counter is reloaded on that same edge. Periods therefore follow each other
// with no gap and are exactly N clocks long.
//
// A new ratio can be written at any time. If the sequencer is idle, the ratio
// takes effect immediately. Otherwise it waits in a one-deep shadow slot and
// becomes active at the next reload, so the period already in progress is not
// disturbed.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | counter parked (no load, no count); waiting for run + cfg
//   LOAD    | one-cycle preload of D_OUT; starts period 1
//   RUN     | counting; RCO from the counter triggers a same-edge reload
//   HOLD    | paused; ENP low freezes Q, RCO ignored
//
// Ports
//   i_clk          rising-edge clock, shared with the driven counter
//   i_clr_n        asynchronous active-low reset
//   i_cfg_valid    new ratio offered on i_cfg_div
//   i_cfg_div      divide ratio N (0 encodes 2^WIDTH)
//   o_cfg_ready    ratio can be accepted (shadow slot empty)
//   i_run_en       1 = run/continue, 0 = pause
//   i_abort        synchronous return to IDLE, highest priority
//   i_rco_in       terminal-count flag from the driven counter
//   o_d_out        parallel load value for the counter
//   o_load_n_out   active-low synchronous load for the counter
//   o_enp_out      counter parallel enable
//   o_ent_out      counter trickle enable
//   o_tick         one-cycle pulse per completed period (registered)
//   o_periods      completed periods since reset, saturating (registered)
//   o_busy         sequencer not in IDLE
// ---------------------------------------------------------------------------
module ls161_div_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_cfg_valid,
  input  logic [WIDTH-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  input  logic             i_run_en,
  input  logic             i_abort,
  input  logic             i_rco_in,
  output logic [WIDTH-1:0] o_d_out,
  output logic             o_load_n_out,
  output logic             o_enp_out,
  output logic             o_ent_out,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_periods,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_active_div;
  logic [WIDTH-1:0]   r_shadow;
  logic               r_shadow_full;
  logic               r_cfg_ok;
  logic               r_tick;
  logic [CNT_W-1:0]   r_periods;

  logic [WIDTH-1:0]   w_next_div;
  logic               w_cfg_accept;
  logic               w_reload;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and counter drive
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    o_load_n_out = 1'b1;
    o_enp_out    = 1'b0;
    o_ent_out    = 1'b0;
    w_reload     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // r_cfg_ok is registered, so a ratio accepted this cycle cannot start
        // the counter before the next cycle.
        if (i_run_en && r_cfg_ok) begin
          w_next_state = ST_LOAD;
        end
      end

      ST_LOAD: begin
        o_load_n_out = 1'b0;
        w_next_state = i_run_en ? ST_RUN : ST_HOLD;
      end

      ST_RUN: begin
        o_enp_out    = 1'b1;
        o_ent_out    = 1'b1;
        // RCO drives the load directly. The reload then happens on the same
        // edge that would otherwise wrap the counter, so periods have no gap.
        o_load_n_out = ~i_rco_in;
        w_reload     = i_rco_in;
        if (!i_run_en) begin
          w_next_state = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // ENT stays high, so RCO still reflects Q; ENP low freezes the count.
        o_ent_out = 1'b1;
        if (i_run_en) begin
          w_next_state = ST_RUN;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Abort overrides everything in the same cycle: no load, no count, no tick.
    if (i_abort) begin
      w_next_state = ST_IDLE;
      o_load_n_out = 1'b1;
      o_enp_out    = 1'b0;
      o_ent_out    = 1'b0;
      w_reload     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load value: while running with a ratio waiting, present the pending ratio
  // so that the next reload picks it up directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_div = r_active_div;
    if ((r_state == ST_RUN) && r_shadow_full) begin
      w_next_div = r_shadow;
    end
  end

  // 2^WIDTH - N, modulo 2^WIDTH; N = 0 wraps to a load of 0, i.e. a full period.
  assign o_d_out      = -w_next_div;

  assign o_cfg_ready  = ~r_shadow_full;
  assign w_cfg_accept = i_cfg_valid & o_cfg_ready;

  // ---------------------------------------------------------------------------
  // Ratio registers and shadow slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_active_div  <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_cfg_ok      <= 1'b0;
    end else begin
      if (w_cfg_accept) begin
        r_cfg_ok <= 1'b1;
        if (r_state == ST_IDLE) begin
          r_active_div <= i_cfg_div;
        end else begin
          r_shadow      <= i_cfg_div;
          r_shadow_full <= 1'b1;
        end
      end
      // An accept and a promotion never coincide: an accept requires the slot
      // to be empty, and a promotion requires it to be full.
      if (w_reload && r_shadow_full) begin
        r_active_div  <= r_shadow;
        r_shadow_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion pulse and saturating period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_tick    <= 1'b0;
      r_periods <= '0;
    end else begin
      r_tick <= w_reload;
      if (w_reload && (r_periods != {CNT_W{1'b1}})) begin
        r_periods <= r_periods + CNT_W'(1);
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_periods = r_periods;
  assign o_busy    = (r_state != ST_IDLE);

endmodule
